key_pulser: RTL and testbench
=============================

Name: key_pulser

Overview:
- Multi-channel debounced rising-edge one-shot generator for the push-button and switch inputs that drive the game controller FSM.
- Each channel filters a raw level input and emits a single-cycle pulse when the filtered level rises.
- Optionally emits typematic auto-repeat pulses while the input is held.
- Sits between board I/O and the control/datapath logic; all outputs are synchronous to the system clock.

Parameters:
- CHANNELS, 4, number of independent input channels (>=1)
- DEBOUNCE_CYCLES, 4, consecutive cycles the raw input must differ from the filtered level before the filtered level flips (>=1)
- REPEAT_DELAY, 8, cycles from the first pulse to the first repeat pulse (>=2; used only with the repeat feature)
- REPEAT_PERIOD, 4, cycles between subsequent repeat pulses (>=2; used only with the repeat feature)

Ports:
- clock  input  1  system clock; all logic on the rising edge
- resetn  input  1  reset, synchronous and active-high; 1 = reset
- enable  input  CHANNELS  raw level inputs, already synchronised upstream
- q  output  CHANNELS  one-cycle pulse per channel
- held  output  CHANNELS  debounced level per channel
- any_pulse  output  1  OR-reduction of q (combinational from registered q)

Behaviour:
- Reset: sampled at a clock edge with resetn=1.
  - q, held, all counters and all FSMs clear.
  - Outputs read 0 in the cycle after that edge.
  - Reset takes priority over every other event.
- Debounce, per channel:
  - cnt (width $clog2(DEBOUNCE_CYCLES+1)) increments on each edge where enable != held.
  - cnt clears on any edge where enable == held.
  - When cnt would reach DEBOUNCE_CYCLES, held toggles and cnt clears.
  - Latency: enable first sampled high at edge n and held stable gives held=1 after edge n+DEBOUNCE_CYCLES-1. Falling edges behave symmetrically.
- FSM per channel: states IDLE, ARMED, REPEAT.
  - IDLE (held=0): on the edge where held goes 0->1, q=1 for exactly the next cycle; state -> ARMED; rpt counter cleared.
  - ARMED: rpt increments each cycle. Without the repeat feature, it stays here until release.
  - REPEAT: rpt counts REPEAT_PERIOD-1 down to 0; pulses on wrap.
  - Any state: on the edge where held goes 1->0, state -> IDLE, rpt cleared, no pulse. This also holds if a repeat pulse was due on the same edge; release wins.
- q is registered and high for a single cycle per event. Pulses are never merged or stretched.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous q bits.
- Reset mid-hold: after reset, held=0. An input still high re-debounces from scratch and yields a fresh pulse DEBOUNCE_CYCLES edges after reset deasserts.
- rpt width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1) and never overflows, because the FSM restarts the count.

Optional Feature:
- Macro: KEY_PULSER_AUTO_REPEAT_EN.
- Defined:
  - ARMED -> REPEAT with a pulse on the edge where rpt reaches REPEAT_DELAY-1. Pulses therefore appear REPEAT_DELAY cycles after the first pulse.
  - REPEAT then pulses every REPEAT_PERIOD cycles until release.
- Undefined:
  - Exactly one pulse per press. REPEAT state and the repeat counter logic are absent.
  - REPEAT_DELAY and REPEAT_PERIOD are ignored.

Decomposition:
- Package key_pulser_pkg holds:
  - typedef enum kp_state_t {KP_IDLE, KP_ARMED, KP_REPEAT}
  - width helper function kp_cw(n) returning $clog2(n+1)
- Sub-module key_pulser_chan: one channel (debounce counter + FSM + rpt counter), instantiated CHANNELS times in a generate loop.
- The top level only instantiates channels and forms any_pulse.

Test Plan (defaults: CHANNELS=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4):
- Clean press: enable[0]=1 from edge 10 -> held[0]=1 and q[0]=1 after edge 13; q[0]=0 after edge 14. Without the macro, no further q[0] through edge 60.
- Glitch: enable[1]=1 at edges 10-12 only -> held[1] and q[1] stay 0 throughout.
- Auto-repeat (macro defined): enable[0] high from edge 10 -> q[0] pulses after edges 13, 21, 25, 29, 33. enable[0] low from edge 34 -> held[0]=0 after edge 37; no pulse at 37 even though a repeat was due.
- Simultaneous: enable[0] and enable[2] rise at edge 5 -> q=4'b0101 for one cycle after edge 8; any_pulse=1 in that cycle only.
- Reset mid-hold: enable[3] high from edge 0, resetn=1 at edge 10 -> q, held =0 after edge 10; with enable[3] still high, pulse after edge 14.
- Release bounce: enable[0] held, then low for 3 edges and high again -> held stays 1, no extra pulse, and repeat timing is unchanged.

Source files
------------

// File: rtl/key_pulser_pkg.sv
// Shared types and helpers for the key_pulser debounced one-shot block.
// Optional auto-repeat is enabled with `define KEY_PULSER_AUTO_REPEAT_EN.
package key_pulser_pkg;

    typedef enum logic [1:0] {
        KP_IDLE   = 2'd0,
        KP_ARMED  = 2'd1,
        KP_REPEAT = 2'd2
    } kp_state_t;

    // Bits needed to hold values 0..n inclusive.
    function automatic int kp_cw(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/key_pulser_chan.sv
// One key_pulser channel: debounce filter, press FSM and (with
// KEY_PULSER_AUTO_REPEAT_EN defined) the typematic repeat counter.
module key_pulser_chan
    import key_pulser_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic clock,
    input  logic resetn,
    input  logic enable,
    output logic q,
    output logic held
);

    localparam int CW = kp_cw(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          held_next;
    logic          rise;
    logic          fall;
    logic          q_next;
    kp_state_t     state;
    kp_state_t     state_next;

    // The filtered level flips on the edge that would complete the run.
    always_comb begin
        held_next = held;
        cnt_next  = '0;
        if (enable != held) begin
            if (cnt == CNT_LAST) begin
                held_next = ~held;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
        rise = held_next & ~held;
        fall = ~held_next & held;
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            held <= 1'b0;
            cnt  <= '0;
        end else begin
            held <= held_next;
            cnt  <= cnt_next;
        end
    end

`ifdef KEY_PULSER_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = kp_cw(RMAX);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rpt;
    logic [RW-1:0] rpt_next;

    // Release is checked before any due repeat so it always wins.
    always_comb begin
        state_next = state;
        q_next     = 1'b0;
        rpt_next   = rpt;
        case (state)
            KP_IDLE: begin
                if (rise) begin
                    state_next = KP_ARMED;
                    q_next     = 1'b1;
                    rpt_next   = '0;
                end
            end
            KP_ARMED: begin
                if (fall) begin
                    state_next = KP_IDLE;
                    rpt_next   = '0;
                end else if (rpt == DELAY_LAST) begin
                    state_next = KP_REPEAT;
                    q_next     = 1'b1;
                    rpt_next   = PERIOD_LAST;
                end else begin
                    rpt_next = rpt + 1'b1;
                end
            end
            KP_REPEAT: begin
                if (fall) begin
                    state_next = KP_IDLE;
                    rpt_next   = '0;
                end else if (rpt == '0) begin
                    q_next   = 1'b1;
                    rpt_next = PERIOD_LAST;
                end else begin
                    rpt_next = rpt - 1'b1;
                end
            end
            default: begin
                state_next = KP_IDLE;
                rpt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            state <= KP_IDLE;
            q     <= 1'b0;
            rpt   <= '0;
        end else begin
            state <= state_next;
            q     <= q_next;
            rpt   <= rpt_next;
        end
    end
`else
    // Repeat timing has no hardware in this build; the block only anchors the parameters.
    if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_repeat_params_unused
    end

    always_comb begin
        state_next = state;
        q_next     = 1'b0;
        case (state)
            KP_IDLE: begin
                if (rise) begin
                    state_next = KP_ARMED;
                    q_next     = 1'b1;
                end
            end
            KP_ARMED: begin
                if (fall) begin
                    state_next = KP_IDLE;
                end
            end
            default: begin
                state_next = KP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            state <= KP_IDLE;
            q     <= 1'b0;
        end else begin
            state <= state_next;
            q     <= q_next;
        end
    end
`endif

endmodule

// File: rtl/key_pulser.sv
// Multi-channel debounced rising-edge one-shot generator (top level).
// Auto-repeat pulses are built only with `define KEY_PULSER_AUTO_REPEAT_EN.
module key_pulser
    import key_pulser_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [CHANNELS-1:0] enable,
    output logic [CHANNELS-1:0] q,
    output logic [CHANNELS-1:0] held,
    output logic                any_pulse
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        key_pulser_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_chan (
            .clock (clock),
            .resetn(resetn),
            .enable(enable[i]),
            .q     (q[i]),
            .held  (held[i])
        );
    end

    assign any_pulse = |q;

endmodule

// File: tb/tb_key_pulser.sv
// Self-checking bench for key_pulser against a run-length/age reference model.
// Honours KEY_PULSER_AUTO_REPEAT_EN the same way the design does.
module tb_key_pulser;

    localparam int CH = 4;
    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 4;

    logic          clock = 1'b0;
    logic          resetn;
    logic [CH-1:0] enable;
    logic [CH-1:0] q;
    logic [CH-1:0] held;
    logic          any_pulse;

    int tests_run    = 0;
    int tests_failed = 0;

    int            run_len [CH];
    int            press_edge [CH];
    logic [CH-1:0] exp_q;
    logic [CH-1:0] exp_held;
    int            edge_no = 0;

    key_pulser #(
        .CHANNELS       (CH),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .enable   (enable),
        .q        (q),
        .held     (held),
        .any_pulse(any_pulse)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at edge %0d: observed %0h, expected %0h", tag, edge_no, observed, expected);
        end
    endtask

    // Reference: a press is a run of DB differing samples; repeats are a function of age since press.
    task automatic modelStep(input logic rst, input logic [CH-1:0] en);
        int age;
        edge_no++;
        for (int c = 0; c < CH; c++) begin
            exp_q[c] = 1'b0;
            if (rst) begin
                exp_held[c] = 1'b0;
                run_len[c]  = 0;
            end else begin
                run_len[c] = (en[c] != exp_held[c]) ? run_len[c] + 1 : 0;
                if (run_len[c] == DB) begin
                    exp_held[c] = en[c];
                    run_len[c]  = 0;
                    if (en[c]) begin
                        press_edge[c] = edge_no;
                        exp_q[c]      = 1'b1;
                    end
                end
`ifdef KEY_PULSER_AUTO_REPEAT_EN
                else if (exp_held[c]) begin
                    age = edge_no - press_edge[c];
                    if (age >= RD && ((age - RD) % RP) == 0) exp_q[c] = 1'b1;
                end
`endif
            end
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [CH-1:0] en, input int cycles);
        for (int n = 0; n < cycles; n++) begin
            resetn = rst;
            enable = en;
            @(posedge clock);
            #1;
            modelStep(rst, en);
            checkOutput("q", 32'(q), 32'(exp_q));
            checkOutput("held", 32'(held), 32'(exp_held));
            checkOutput("any_pulse", 32'(any_pulse), 32'(|exp_q));
        end
    endtask

    initial begin
        logic [CH-1:0] rnd_en;
        logic          rnd_rst;

        for (int c = 0; c < CH; c++) begin
            run_len[c]    = 0;
            press_edge[c] = 0;
        end
        exp_q    = '0;
        exp_held = '0;
        resetn   = 1'b1;
        enable   = '0;

        applyStimulus(1'b1, 4'b0000, 2);
        checkOutput("reset_held", 32'(held), 32'd0);

        // Two channels rising together fire in the same cycle, once.
        applyStimulus(1'b0, 4'b0101, 3);
        checkOutput("simul_pre", 32'(q), 32'd0);
        applyStimulus(1'b0, 4'b0101, 1);
        checkOutput("simul_q", 32'(q), 32'h5);
        checkOutput("simul_any", 32'(any_pulse), 32'd1);
        applyStimulus(1'b0, 4'b0101, 1);
        checkOutput("simul_once", 32'(any_pulse), 32'd0);
        applyStimulus(1'b0, 4'b0000, 6);

        applyStimulus(1'b0, 4'b0010, 3);
        applyStimulus(1'b0, 4'b0000, 5);
        checkOutput("glitch_held", 32'(held[1]), 32'd0);

        // Long hold with a short release bounce, then a real release.
        applyStimulus(1'b0, 4'b0001, 30);
        applyStimulus(1'b0, 4'b0000, 3);
        checkOutput("bounce_held", 32'(held[0]), 32'd1);
        applyStimulus(1'b0, 4'b0001, 20);
        applyStimulus(1'b0, 4'b0000, 8);

        applyStimulus(1'b0, 4'b1000, 10);
        applyStimulus(1'b1, 4'b1000, 1);
        checkOutput("rst_held", 32'(held), 32'd0);
        applyStimulus(1'b0, 4'b1000, 3);
        checkOutput("rst_quiet", 32'(q), 32'd0);
        applyStimulus(1'b0, 4'b1000, 1);
        checkOutput("rst_refire", 32'(q), 32'h8);
        applyStimulus(1'b0, 4'b0000, 6);

        rnd_en = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(7) == 0) rnd_en[c] = ~rnd_en[c];
            end
            rnd_rst = ($urandom_range(399) == 0);
            applyStimulus(rnd_rst, rnd_en, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
